// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin ownership of one shared slave bus.
// Latency: grant registered, one cycle from mX cyc to s_wb_cyc_o; data/ack/err paths combinational.
// Backpressure: the losing master simply waits with cyc high; a stalled slave holds the grant
// unless the optional stall timeout (macro WB_ARB_TIMEOUT_EN) is compiled in.
module wb_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // master 0
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  // master 1
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  // shared slave bus
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  // current owner, one-hot
  output logic [1:0]  o_grant
);

  // Encoding is chosen so the state register is the one-hot grant vector itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  // Round-robin pointer: 0 favours master 0 on a tie, 1 favours master 1.
  logic   r_prio;
  logic   w_prio_nxt;

  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_to_err;

  assign w_gnt0  = (r_state == GNT0);
  assign w_gnt1  = (r_state == GNT1);
  assign o_grant = r_state;

  // State and round-robin pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Next-state: grant from IDLE, hold while owner keeps cyc, release through IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    case (r_state)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          w_state_nxt = r_prio ? GNT1 : GNT0;
        end else if (m0_wb_cyc_i) begin
          w_state_nxt = GNT0;
        end else if (m1_wb_cyc_i) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_wb_cyc_i) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = 1'b1;
        end
      end
      GNT1: begin
        if (!m1_wb_cyc_i) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request mux: owner's signals onto the slave bus, all zero when idle.
  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_adr_o = 32'h0;
    s_wb_dat_o = 32'h0;
    s_wb_sel_o = 4'h0;
    if (w_gnt0) begin
      s_wb_cyc_o = m0_wb_cyc_i;
      s_wb_stb_o = m0_wb_stb_i;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_dat_o = m0_wb_dat_i;
      s_wb_sel_o = m0_wb_sel_i;
    end else if (w_gnt1) begin
      s_wb_cyc_o = m1_wb_cyc_i;
      s_wb_stb_o = m1_wb_stb_i;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_dat_o = m1_wb_dat_i;
      s_wb_sel_o = m1_wb_sel_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Count of consecutive stalled strobe cycles already completed.
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;
  logic        w_stall;

  assign w_stall  = s_wb_stb_o && !s_wb_ack_i && !s_wb_err_i;
  // Fires during the TIMEOUT_CYCLES-th stalled cycle; the count restarts afterwards.
  assign w_to_err = w_stall && (r_to_cnt == LP_TO_LAST);

  // Stall counter: cleared by any response, by strobe low, or by its own error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_to_cnt <= 16'h0;
    end else if (!w_stall || w_to_err) begin
      r_to_cnt <= 16'h0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'h1;
    end
  end
`else
  assign w_to_err = 1'b0;
`endif

  // Response routing: read data to both, ack/err only to the owner.
  always_comb begin
    m0_wb_dat_o = s_wb_dat_i;
    m1_wb_dat_o = s_wb_dat_i;
    m0_wb_ack_o = w_gnt0 && s_wb_ack_i;
    m1_wb_ack_o = w_gnt1 && s_wb_ack_i;
    m0_wb_err_o = w_gnt0 && (s_wb_err_i || w_to_err);
    m1_wb_err_o = w_gnt1 && (s_wb_err_i || w_to_err);
  end

endmodule
